// File: rtl/calc_keys.sv
// rtl/calc_keys.sv - shared calculator keycode constants
// Purpose: 5-bit keycodes exchanged between the keypad scanner and the calculator core.
// Ports: none (package).
package calc_keys;

    localparam logic       DIGIT_PREFIX = 1'b1;   // digits are {1'b1, value[3:0]}

    localparam logic [4:0] KEY_SQR      = 5'b00001;
    localparam logic [4:0] KEY_CH_SIGN  = 5'b00010;
    localparam logic [4:0] KEY_EQUALS   = 5'b00011;
    localparam logic [4:0] KEY_CA       = 5'b00100;
    localparam logic [4:0] KEY_MULTI    = 5'b01001;
    localparam logic [4:0] KEY_SUB      = 5'b01010;
    localparam logic [4:0] KEY_ADD      = 5'b01011;
    localparam logic [4:0] KEY_CE       = 5'b01100;

endpackage

// File: rtl/key_debounce_counter.sv
// rtl/key_debounce_counter.sv - consecutive-cycle counter used for press and release debounce
// Purpose: counts enabled cycles; done pulses on the LENGTH-th consecutive enabled cycle.
// Ports: clk, rst (async, active-high), en (count this cycle), clr (restart), done (length reached).
module key_debounce_counter #(
    parameter int LENGTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic done
);

    localparam int             CW   = $clog2(LENGTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(LENGTH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic [CW-1:0] count;

    // done is combinational so the owner can act in the same cycle the run completes
    assign done = en && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x6 key matrix scanner with debounce and single newkey strobe
// Purpose: drives one column low at a time, synchronises rows, debounces press and release,
//          and emits one keycode with a one-cycle newkey strobe per physical press.
// Ports: clk, rst (async, active-high), row_n[3:0] (async, active-low rows),
//        col_n[5:0] (one-low column drive), keycode[4:0], newkey (strobe), key_down (held flag).
module keypad_scanner
    import calc_keys::*;
#(
    parameter int SETTLE_CYCLES   = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [5:0] col_n,
    output logic [4:0] keycode,
    output logic       newkey,
    output logic       key_down
);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HELD} state_t;

    localparam int            SW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);

    state_t        state;
    logic [2:0]    col;
    logic [SW-1:0] settle_cnt;
    logic [3:0]    pattern;
    logic [3:0]    row_meta;
    logic [3:0]    row_s;
    logic          row_idle;
    logic          row_match;
    logic          cnt_en;
    logic          cnt_done;

    function automatic logic [2:0] next_col(input logic [2:0] c);
        return (c == 3'd5) ? 3'd0 : c + 3'd1;
    endfunction

    function automatic logic [5:0] col_drive(input logic [2:0] c);
        return ~(6'b000001 << c);
    endfunction

    // Lowest-index low row wins when several rows of one column are low.
    function automatic logic [4:0] key_map(input logic [2:0] c, input logic [3:0] rows);
        logic [1:0] r;
        logic [4:0] code;
        if (!rows[0])      r = 2'd0;
        else if (!rows[1]) r = 2'd1;
        else if (!rows[2]) r = 2'd2;
        else               r = 2'd3;
        code = {DIGIT_PREFIX, r, c[1:0]};
        if (c == 3'd4) begin
            case (r)
                2'd0:    code = KEY_CA;
                2'd1:    code = KEY_CE;
                2'd2:    code = KEY_SQR;
                default: code = KEY_CH_SIGN;
            endcase
        end else if (c == 3'd5) begin
            case (r)
                2'd0:    code = KEY_ADD;
                2'd1:    code = KEY_SUB;
                2'd2:    code = KEY_MULTI;
                default: code = KEY_EQUALS;
            endcase
        end
        return code;
    endfunction

    // Two-flop synchroniser; row_n is asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'b1111;
            row_s    <= 4'b1111;
        end else begin
            row_meta <= row_n;
            row_s    <= row_meta;
        end
    end

    assign row_idle  = (row_s == 4'b1111);
    assign row_match = (row_s == pattern);

    // One counter serves both phases: stable press in DEBOUNCE, stable release in HELD.
    // Any cycle that does not extend the current run clears it.
    assign cnt_en = ((state == DEBOUNCE) && row_match) || ((state == HELD) && row_idle);

    key_debounce_counter #(
        .LENGTH (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (!cnt_en),
        .done (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SCAN;
            col        <= 3'd0;
            col_n      <= 6'b111110;
            settle_cnt <= '0;
            pattern    <= 4'b1111;
            keycode    <= 5'b00000;
            newkey     <= 1'b0;
            key_down   <= 1'b0;
        end else begin
            newkey <= 1'b0;
            case (state)
                SCAN: begin
                    if (settle_cnt != SETTLE_LAST) begin
                        settle_cnt <= settle_cnt + SETTLE_ONE;
                    end else begin
                        settle_cnt <= '0;
                        if (row_idle) begin
                            col   <= next_col(col);
                            col_n <= col_drive(next_col(col));
                        end else begin
                            pattern <= row_s;
                            state   <= DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!row_match) begin
                        state <= SCAN;
                    end else if (cnt_done) begin
                        // outputs are registered, so they are loaded on entry to EMIT
                        keycode  <= key_map(col, pattern);
                        newkey   <= 1'b1;
                        key_down <= 1'b1;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    state <= HELD;
                end
                HELD: begin
                    if (cnt_done) begin
                        key_down <= 1'b0;
                        col      <= next_col(col);
                        col_n    <= col_drive(next_col(col));
                        state    <= SCAN;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
